// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider and its future unrolled variant.
package div_pkg;

    localparam int N_W_DEF = 8;
    localparam int D_W_DEF = 4;

    // Width of the step counter; never below one bit so a 1-bit dividend still builds.
    function automatic int cnt_width(input int n_w);
        return (n_w <= 2) ? 1 : $clog2(n_w);
    endfunction

    localparam int CNT_W = cnt_width(N_W_DEF);

    // Quotient reported on divide-by-zero: all ones.
    localparam logic [N_W_DEF-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int D_W = div_pkg::D_W_DEF
) (
    input  logic [D_W-1:0] r_in,
    input  logic           q_msb,
    input  logic [D_W-1:0] d,
    output logic [D_W-1:0] r_next,
    output logic           q_bit
);

    logic [D_W:0] t;

    // R is always below D, so a successful subtraction fits back into D_W bits
    // and the low D_W bits of the modular difference are exact.
    always_comb begin
        t      = {r_in, q_msb};
        q_bit  = (t >= {1'b0, d});
        r_next = q_bit ? (t[D_W-1:0] - d) : t[D_W-1:0];
    end

endmodule

// File: rtl/seq_div_8by4.sv
// Iterative restoring divider, one quotient bit per cycle, valid/ready on both sides.
module seq_div_8by4
    import div_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           dbz
);

    localparam int LOC_CNT_W = cnt_width(N_W);

    div_state_t           state;
    logic [N_W-1:0]       q_reg;
    logic [D_W-1:0]       d_reg;
    logic [D_W-1:0]       r_reg;
    logic [LOC_CNT_W-1:0] count;

    logic [D_W-1:0]       r_next;
    logic                 q_bit;
    logic [N_W-1:0]       q_next;

    div_step #(
        .D_W (D_W)
    ) u_step (
        .r_in   (r_reg),
        .q_msb  (q_reg[N_W-1]),
        .d      (d_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    assign q_next   = {q_reg[N_W-2:0], q_bit};
    assign in_ready = (state == IDLE);

    // Control and datapath in one block; results are registered on the final step
    // so outputs stay frozen through DONE regardless of the working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        count <= LOC_CNT_W'(N_W - 1);
                        if (divisor == '0) begin
                            quotient  <= DBZ_QUOTIENT;
                            remainder <= '0;
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count - LOC_CNT_W'(1);
                    if (count == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        dbz       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_8by4.sv
// Self-checking bench for seq_div_8by4: directed table, handshake corner cases, full operand sweep.
module tb_seq_div_8by4;

    localparam int N_W = 8;
    localparam int D_W = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           out_valid;
    logic           out_ready;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           dbz;

    int vectors;
    int miscompares;

    typedef struct {
        logic [N_W-1:0] a;
        logic [D_W-1:0] b;
        logic [N_W-1:0] q;
        logic [D_W-1:0] r;
        bit             z;
    } vec_t;

    vec_t vecs[10];

    seq_div_8by4 #(
        .N_W (N_W),
        .D_W (D_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung handshake.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain integer division, all-ones quotient on zero divisor.
    function automatic void model(input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                                  output logic [N_W-1:0] q, output logic [D_W-1:0] r,
                                  output bit z);
        if (b == '0) begin
            q = '1;
            r = '0;
            z = 1'b1;
        end else begin
            q = a / {4'b0, b};
            r = D_W'(a % {4'b0, b});
            z = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Issue one operation from IDLE; returns edges after accept until out_valid,
    // and whether in_ready stayed low the whole time.
    task automatic applyStimulus(input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                                 output int lat, output bit ready_low);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = N_W'($urandom);
        divisor   = D_W'($urandom);
        lat       = 0;
        ready_low = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_low = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready) ready_low = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Hold the result for some cycles, then take it and confirm return to IDLE.
    task automatic drainOutput(input int stall, input logic [N_W-1:0] eq,
                               input logic [D_W-1:0] er, input bit ez);
        bit stable;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stable    = 1'b1;
        repeat (stall) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || quotient != eq || remainder != er || dbz != ez)
                stable = 1'b0;
        end
        if (stall > 0) checkOutput("hold_stable", int'(stable), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("release_out_valid", int'(out_valid), 0);
        checkOutput("release_in_ready", int'(in_ready), 1);
    endtask

    task automatic runOp(input string tag, input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                         input int stall);
        logic [N_W-1:0] eq;
        logic [D_W-1:0] er;
        bit             ez;
        int             lat;
        bit             ready_low;
        model(a, b, eq, er, ez);
        applyStimulus(a, b, lat, ready_low);
        checkOutput({tag, "_quotient"}, int'(quotient), int'(eq));
        checkOutput({tag, "_remainder"}, int'(remainder), int'(er));
        checkOutput({tag, "_dbz"}, int'(dbz), int'(ez));
        checkOutput({tag, "_latency"}, lat, ez ? 0 : N_W);
        checkOutput({tag, "_in_ready_low"}, int'(ready_low), 1);
        if (b != '0)
            checkOutput({tag, "_invariant"},
                        int'((int'(quotient) * int'(b) + int'(remainder) == int'(a))
                             && (remainder < b)), 1);
        drainOutput(stall, eq, er, ez);
    endtask

    initial begin
        int  lat;
        bit  ready_low;

        vectors     = 0;
        miscompares = 0;

        vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4,  z: 1'b0};
        vecs[1] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0,  z: 1'b0};
        vecs[2] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0,  z: 1'b0};
        vecs[3] = '{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0,  z: 1'b0};
        vecs[4] = '{a: 8'd3,   b: 4'd9,  q: 8'd0,   r: 4'd3,  z: 1'b0};
        vecs[5] = '{a: 8'd123, b: 4'd0,  q: 8'hFF,  r: 4'd0,  z: 1'b1};
        vecs[6] = '{a: 8'd100, b: 4'd3,  q: 8'd33,  r: 4'd1,  z: 1'b0};
        vecs[7] = '{a: 8'd254, b: 4'd3,  q: 8'd84,  r: 4'd2,  z: 1'b0};
        vecs[8] = '{a: 8'd1,   b: 4'd15, q: 8'd0,   r: 4'd1,  z: 1'b0};
        vecs[9] = '{a: 8'd239, b: 4'd14, q: 8'd17,  r: 4'd1,  z: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_quotient", int'(quotient), 0);
        checkOutput("reset_remainder", int'(remainder), 0);
        checkOutput("reset_dbz", int'(dbz), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat, ready_low);
            checkOutput("table_quotient", int'(quotient), int'(vecs[i].q));
            checkOutput("table_remainder", int'(remainder), int'(vecs[i].r));
            checkOutput("table_dbz", int'(dbz), int'(vecs[i].z));
            checkOutput("table_latency", lat, vecs[i].z ? 0 : N_W);
            checkOutput("table_in_ready_low", int'(ready_low), 1);
            drainOutput(0, vecs[i].q, vecs[i].r, vecs[i].z);
        end

        $display("[TB] back-pressure then back-to-back accept");
        applyStimulus(8'd255, 4'd15, lat, ready_low);
        checkOutput("bp_quotient", int'(quotient), 17);
        drainOutput(5, 8'd17, 4'd0, 1'b0);
        applyStimulus(8'd3, 4'd9, lat, ready_low);
        checkOutput("bp_next_latency", lat, N_W);
        checkOutput("bp_next_remainder", int'(remainder), 3);
        drainOutput(1, 8'd0, 4'd3, 1'b0);

        $display("[TB] reset during BUSY");
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_quotient", int'(quotient), 0);
        checkOutput("abort_remainder", int'(remainder), 0);
        checkOutput("abort_dbz", int'(dbz), 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(8'd100, 4'd3, lat, ready_low);
        checkOutput("post_abort_quotient", int'(quotient), 33);
        checkOutput("post_abort_remainder", int'(remainder), 1);
        checkOutput("post_abort_latency", lat, N_W);
        drainOutput(0, 8'd33, 4'd1, 1'b0);

        $display("[TB] random operands");
        for (int i = 0; i < 24; i++)
            runOp("rand", N_W'($urandom), D_W'($urandom), $urandom_range(0, 3));

        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                runOp("sweep", N_W'(a), D_W'(b), $urandom_range(0, 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
